demux_rr_sequencer_v: RTL
=========================

// Module: demux_rr_sequencer_v
// PURPOSE
//  Upstream feeder for the 1:8 demultiplexer stage.
//  - Accepts a serial bit stream on a valid/ready handshake.
//  - Emits a registered data bit plus a 3-bit select code.
//  - Distributes bits round-robin across the enabled output channels, BURST_LEN bits per channel.
//  - o_a / o_sel_code connect directly to the demux i_a / i_sel_code.
// PARAMETERS
//  BURST_LEN  4  bits sent to a channel before advancing; legal 1..16
// PORTS
//  i_clk        in   1  sole clock, rising edge
//  i_rst        in   1  reset, synchronous, active-high
//  i_data       in   1  input data bit
//  i_valid      in   1  i_data valid this cycle
//  o_ready      out  1  block accepts i_data this cycle
//  i_chan_en    in   8  per-channel enable mask, bit n = channel n
//  o_a          out  1  registered data bit to demux; 0 whenever o_valid=0
//  o_sel_code   out  3  registered channel index for o_a
//  o_valid      out  1  o_a/o_sel_code carry an accepted bit
//  o_wrap       out  1  1-cycle pulse when channel pointer wraps (new index < old index)
// BEHAVIOUR
//  Clock and reset
//  - Single clock; reset is synchronous and active-high.
//  - i_rst has priority over every event in the same cycle, including a pending accept.
//  - Reset values: state=IDLE, cur=0, cnt=0, o_a=0, o_sel_code=0, o_valid=0, o_wrap=0.
//  Internal state
//  - cur = channel pointer (3 b); cnt = burst counter (width ceil(log2(BURST_LEN))+1).
//  - nxt(cur) = first enabled channel scanning cur+1, cur+2, ... cur+8, mod 8.
//    nxt(cur) may equal cur if cur is the only enabled channel.
//  States
//  - IDLE: i_chan_en==0.
//    o_ready=0.
//    -> RUN when i_chan_en!=0; cur <= lowest enabled index, cnt <= 0.
//  - RUN: o_ready = i_chan_en[cur].
//    -> IDLE when i_chan_en==0; o_ready=0 that cycle, cnt <= 0, no accept.
//  Accept (RUN, i_valid & o_ready)
//  - Next cycle: o_valid=1, o_a=i_data, o_sel_code=cur. Latency is exactly 1 cycle.
//  - If cnt==BURST_LEN-1: cur <= nxt(cur), cnt <= 0.
//  - Otherwise: cnt <= cnt+1.
//  No accept
//  - Next cycle: o_valid=0, o_a=0. o_sel_code holds its last value.
//  Masked current channel (RUN, i_chan_en[cur]==0 but mask!=0)
//  - o_ready=0 for that cycle.
//  - cur <= nxt(cur), cnt <= 0. Costs exactly one bubble cycle.
//  Mask sampling
//  - Mask changes take effect the cycle they are applied.
//  - A bit already accepted always completes on its registered channel.
//  Wrap
//  - o_wrap=1 in the cycle after any cur update whose new index < old index.
//  - No pulse when nxt(cur)==cur.
//  Handshake
//  - No output backpressure; the downstream demux always consumes.
//  - o_valid is never asserted without a corresponding accept.
// TESTING
//  T1 Reset
//     Assert i_rst with i_valid=1, mask=FF.
//     -> Next cycle: o_valid=0, o_a=0, o_sel_code=0, o_ready=0 (IDLE).
//  T2 Full round-robin
//     BURST_LEN=4, mask=FF, 32 bits streamed back-to-back.
//     -> o_sel_code = 0,0,0,0,1,1,1,1,...,7,7,7,7.
//     -> o_wrap pulses after the 32nd bit; o_valid high for 32 consecutive cycles.
//  T3 Sparse mask
//     mask=8'b1000_0100, BURST_LEN=1, 4 bits.
//     -> sel = 2,7,2,7; o_wrap pulses after each 7->2 step.
//  T4 Mask drop mid-burst
//     On channel 3 with cnt=2, clear bit 3 (mask=F7).
//     -> One cycle o_ready=0, then next bit lands on channel 4 with cnt restarted.
//  T5 Mask to zero, then restore
//     Set mask=00 mid-stream.
//     -> o_ready=0, IDLE, o_valid=0 after the last accepted bit drains.
//     Then mask=8'h20.
//     -> Next bits go to channel 5.
//  T6 Gaps in i_valid
//     Toggle i_valid 1,0,1,0.
//     -> o_valid=1,0,1,0 delayed 1 cycle; o_a=0 in gap cycles; cnt unchanged in gaps.

Source files
------------

// File: rtl/demux_rr_sequencer_v.sv
// Round-robin feeder for the 1:8 demux: accepts a serial bit stream and tags each
// accepted bit with the channel it belongs to, BURST_LEN bits per enabled channel.
module demux_rr_sequencer_v #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_chan_en,
  output logic       o_a,
  output logic [2:0] o_sel_code,
  output logic       o_valid,
  output logic       o_wrap
);

  localparam int unsigned CW = $clog2(BURST_LEN) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [2:0]    r_cur;
  logic [CW-1:0] r_cnt;

  logic [0:0]    w_state_new;
  logic [2:0]    w_cur_new;
  logic [CW-1:0] w_cnt_new;
  logic [2:0]    w_nxt;
  logic [2:0]    w_low;
  logic          w_accept;

  // Scan from the far end so the nearest enabled channel after r_cur wins;
  // offset 8 lands back on r_cur, covering the single-channel case.
  always_comb begin
    w_nxt = r_cur;
    for (int unsigned k = 8; k >= 1; k--) begin
      if (i_chan_en[3'(r_cur + 3'(k))]) w_nxt = 3'(r_cur + 3'(k));
    end
  end

  always_comb begin
    w_low = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (i_chan_en[i-1]) w_low = 3'(i - 1);
    end
  end

  always_comb begin
    w_state_new = r_state;
    w_cur_new   = r_cur;
    w_cnt_new   = r_cnt;
    w_accept    = 1'b0;
    o_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_chan_en) begin
          w_state_new = ST_RUN;
          w_cur_new   = w_low;
          w_cnt_new   = '0;
        end
      end
      ST_RUN: begin
        if (i_chan_en == 8'h00) begin
          w_state_new = ST_IDLE;
          w_cnt_new   = '0;
        end else if (!i_chan_en[r_cur]) begin
          w_cur_new = w_nxt;
          w_cnt_new = '0;
        end else begin
          o_ready = 1'b1;
          if (i_valid) begin
            w_accept = 1'b1;
            if (r_cnt == CW'(BURST_LEN - 1)) begin
              w_cur_new = w_nxt;
              w_cnt_new = '0;
            end else begin
              w_cnt_new = r_cnt + 1'b1;
            end
          end
        end
      end
      default: w_state_new = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_cnt      <= '0;
      o_a        <= 1'b0;
      o_sel_code <= '0;
      o_valid    <= 1'b0;
      o_wrap     <= 1'b0;
    end else begin
      r_state <= w_state_new;
      r_cur   <= w_cur_new;
      r_cnt   <= w_cnt_new;
      o_valid <= w_accept;
      o_a     <= w_accept & i_data;
      if (w_accept) o_sel_code <= r_cur;
      o_wrap  <= (w_cur_new < r_cur);
    end
  end

endmodule
